// File: rtl/rtc_bus_ctrl.sv
// -----------------------------------------------------------------------------
// rtc_bus_ctrl
//
// Bus-side responder between the menu/scan FSM and the parallel RTC pads.
// Each request (a rising edge on Acceso) runs one multiplexed address/data
// transaction on the RTC bus. Each transaction reports completion with a
// one-cycle FRW pulse. After every reset the block first runs the RTC
// initialisation sequence: write 0x10 to register 0x02, a gap, then write
// 0x00 to register 0x02. That sequence ends with one FRW pulse.
//
// A transaction is seven bus phases, each T_PH clocks long:
//   ADDR_SU -> ADDR_STB -> ADDR_HLD -> GAP -> DATA_SU -> DATA_STB -> DATA_HLD
// The DONE cycle that follows carries FRW. Back-to-back internal writes are
// separated by a CHAIN_GAP of T_PH clocks with the chip deselected.
//
// All bus and handshake outputs are registered. Their next values are
// decoded from the next state, so the pads change exactly on the phase
// boundaries and never glitch.
//
// Optional feature (compile-time macro RTC_AUTO_CMD_EN):
//   When defined, every user write whose address differs from CMD_ADDR is
//   followed automatically by a CHAIN_GAP and a write of 0x00 to CMD_ADDR.
//   FRW is reported only after that command write. Reads are unaffected.
//   When undefined, a user write completes on its own.
//
// Parameters:
//   T_PH      clock cycles per bus phase (>= 2)
//   CMD_ADDR  command register address (only used with RTC_AUTO_CMD_EN)
//
// Ports:
//   CLK      in   clock
//   RST      in   asynchronous active-high reset
//   Acceso   in   request; a rising edge starts a transaction
//   Mod      in   1 = write, 0 = read (sampled on the start edge)
//   Dir      in   [7:0] RTC register address (sampled on the start edge)
//   Dato_wr  in   [7:0] write data (sampled on the start edge)
//   FRW      out  one-cycle pulse: transaction or init sequence complete
//   Dato_rd  out  [7:0] last read data
//   Busy     out  high while init or a transaction is in progress
//   CS_n     out  RTC chip select, active-low
//   AD_n     out  0 = address phase, 1 = data phase
//   WR_n     out  write strobe, active-low
//   RD_n     out  read strobe, active-low
//   AD_out   out  [7:0] bus drive value
//   AD_oe    out  bus output enable (the top level builds the tristate)
//   AD_in    in   [7:0] bus sample value
// -----------------------------------------------------------------------------
module rtc_bus_ctrl #(
   parameter int unsigned T_PH     = 4,
   parameter logic [7:0]  CMD_ADDR = 8'hF1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Acceso,
   input  logic       Mod,
   input  logic [7:0] Dir,
   input  logic [7:0] Dato_wr,
   output logic       FRW,
   output logic [7:0] Dato_rd,
   output logic       Busy,
   output logic       CS_n,
   output logic       AD_n,
   output logic       WR_n,
   output logic       RD_n,
   output logic [7:0] AD_out,
   output logic       AD_oe,
   input  logic [7:0] AD_in
);

`ifdef RTC_AUTO_CMD_EN
   localparam bit AUTO_CMD = 1'b1;
`else
   localparam bit AUTO_CMD = 1'b0;
`endif

   localparam int unsigned PH_W = (T_PH > 1) ? $clog2(T_PH) : 1;

   // Register and values written by the power-up initialisation sequence.
   localparam logic [7:0] INIT_ADDR = 8'h02;
   localparam logic [7:0] INIT_VAL1 = 8'h10;
   localparam logic [7:0] INIT_VAL2 = 8'h00;
   localparam logic [7:0] CMD_VAL   = 8'h00;

   // INIT1 is the state held during reset. It launches the first init
   // write on the first clock after release, so no bus cycle is spent there.
   typedef enum logic [3:0] {
      INIT1,
      IDLE,
      ADDR_SU,
      ADDR_STB,
      ADDR_HLD,
      GAP,
      DATA_SU,
      DATA_STB,
      DATA_HLD,
      CHAIN_GAP,
      DONE
   } state_t;

   // Records which transaction is on the bus. DATA_HLD uses it to decide
   // whether another write is chained or the sequence is complete.
   typedef enum logic [1:0] {
      JOB_INIT1,
      JOB_INIT2,
      JOB_USER,
      JOB_CMD
   } job_t;

   state_t            state_reg, state_next;
   logic [PH_W-1:0]   phase_reg, phase_next;
   job_t              job_reg, job_next;
   logic [7:0]        addr_reg, addr_next;
   logic [7:0]        data_reg, data_next;
   logic              wr_reg, wr_next;
   logic              acc_prev_reg;
   logic [7:0]        dato_rd_reg;

   logic              cs_n_reg, cs_n_next;
   logic              ad_n_reg, ad_n_next;
   logic              wr_n_reg, wr_n_next;
   logic              rd_n_reg, rd_n_next;
   logic              oe_reg, oe_next;
   logic [7:0]        out_reg, out_next;
   logic              frw_reg, frw_next;
   logic              busy_reg, busy_next;

   logic              acc_edge;
   logic              phase_tc;
   logic              rd_capture;

   // acc_prev_reg resets to 1. A request held high through reset is
   // therefore not mistaken for a new edge.
   assign acc_edge   = Acceso & ~acc_prev_reg;
   assign phase_tc   = (phase_reg == PH_W'(T_PH - 1));
   // Read data is sampled on the last clock of the read strobe.
   assign rd_capture = (state_reg == DATA_STB) && phase_tc && !wr_reg;

   // -------------------------------------------------------------------------
   // State register and latched transaction parameters
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg    <= INIT1;
         phase_reg    <= '0;
         job_reg      <= JOB_USER;
         addr_reg     <= '0;
         data_reg     <= '0;
         wr_reg       <= 1'b0;
         acc_prev_reg <= 1'b1;
         dato_rd_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         phase_reg    <= phase_next;
         job_reg      <= job_next;
         addr_reg     <= addr_next;
         data_reg     <= data_next;
         wr_reg       <= wr_next;
         acc_prev_reg <= Acceso;
         if (rd_capture) begin
            dato_rd_reg <= AD_in;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic. Each timed state lasts T_PH clocks. The shared phase
   // counter advances the state on its terminal count.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg;
      job_next   = job_reg;
      addr_next  = addr_reg;
      data_next  = data_reg;
      wr_next    = wr_reg;

      case (state_reg)
         INIT1: begin
            state_next = ADDR_SU;
            phase_next = '0;
            job_next   = JOB_INIT1;
            addr_next  = INIT_ADDR;
            data_next  = INIT_VAL1;
            wr_next    = 1'b1;
         end

         IDLE: begin
            phase_next = '0;
            if (acc_edge) begin
               state_next = ADDR_SU;
               job_next   = JOB_USER;
               addr_next  = Dir;
               data_next  = Dato_wr;
               wr_next    = Mod;
            end
         end

         DONE: begin
            // Edges seen in this cycle are dropped: only IDLE accepts one.
            state_next = IDLE;
            phase_next = '0;
         end

         default: begin
            if (phase_tc) begin
               phase_next = '0;
               case (state_reg)
                  ADDR_SU:   state_next = ADDR_STB;
                  ADDR_STB:  state_next = ADDR_HLD;
                  ADDR_HLD:  state_next = GAP;
                  GAP:       state_next = DATA_SU;
                  DATA_SU:   state_next = DATA_STB;
                  DATA_STB:  state_next = DATA_HLD;
                  CHAIN_GAP: state_next = ADDR_SU;
                  DATA_HLD: begin
                     if (job_reg == JOB_INIT1) begin
                        // Second init write goes to the same register.
                        state_next = CHAIN_GAP;
                        job_next   = JOB_INIT2;
                        data_next  = INIT_VAL2;
                        wr_next    = 1'b1;
                     end else if (AUTO_CMD && (job_reg == JOB_USER) &&
                                  wr_reg && (addr_reg != CMD_ADDR)) begin
                        // A user write is followed by a command-register
                        // write. FRW waits for that command write.
                        state_next = CHAIN_GAP;
                        job_next   = JOB_CMD;
                        addr_next  = CMD_ADDR;
                        data_next  = CMD_VAL;
                        wr_next    = 1'b1;
                     end else begin
                        state_next = DONE;
                     end
                  end
                  default:   state_next = IDLE;
               endcase
            end else begin
               phase_next = phase_reg + PH_W'(1);
            end
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output decode from the next state. The output registers then hold the
   // bus pattern of the state currently in progress.
   // -------------------------------------------------------------------------
   always_comb begin
      cs_n_next = 1'b1;
      ad_n_next = 1'b1;
      wr_n_next = 1'b1;
      rd_n_next = 1'b1;
      oe_next   = 1'b0;
      out_next  = '0;

      case (state_next)
         ADDR_SU, ADDR_HLD: begin
            cs_n_next = 1'b0;
            ad_n_next = 1'b0;
            oe_next   = 1'b1;
            out_next  = addr_next;
         end
         ADDR_STB: begin
            cs_n_next = 1'b0;
            ad_n_next = 1'b0;
            wr_n_next = 1'b0;
            oe_next   = 1'b1;
            out_next  = addr_next;
         end
         DATA_SU, DATA_HLD: begin
            cs_n_next = 1'b0;
            oe_next   = wr_next;
            out_next  = wr_next ? data_next : 8'h00;
         end
         DATA_STB: begin
            // A write uses WR_n and a read uses RD_n. They are never low
            // together.
            cs_n_next = 1'b0;
            wr_n_next = ~wr_next;
            rd_n_next = wr_next;
            oe_next   = wr_next;
            out_next  = wr_next ? data_next : 8'h00;
         end
         default: begin
         end
      endcase

      frw_next  = (state_next == DONE);
      busy_next = (state_next != IDLE);
   end

   // Output registers. The asynchronous reset releases the bus and
   // deasserts every strobe immediately, even in the middle of a transaction.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cs_n_reg <= 1'b1;
         ad_n_reg <= 1'b1;
         wr_n_reg <= 1'b1;
         rd_n_reg <= 1'b1;
         oe_reg   <= 1'b0;
         out_reg  <= '0;
         frw_reg  <= 1'b0;
         busy_reg <= 1'b1;
      end else begin
         cs_n_reg <= cs_n_next;
         ad_n_reg <= ad_n_next;
         wr_n_reg <= wr_n_next;
         rd_n_reg <= rd_n_next;
         oe_reg   <= oe_next;
         out_reg  <= out_next;
         frw_reg  <= frw_next;
         busy_reg <= busy_next;
      end
   end

   assign CS_n    = cs_n_reg;
   assign AD_n    = ad_n_reg;
   assign WR_n    = wr_n_reg;
   assign RD_n    = rd_n_reg;
   assign AD_oe   = oe_reg;
   assign AD_out  = out_reg;
   assign FRW     = frw_reg;
   assign Busy    = busy_reg;
   assign Dato_rd = dato_rd_reg;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_ctrl
//
// Directed bench for rtc_bus_ctrl. A timeline model turns each accepted
// request into the per-cycle bus pattern it must produce. The compare
// process checks every DUT output against that timeline on every cycle.
// The stimulus process also checks a set of hand-computed literal values
// at fixed cycle offsets.
// Inputs change 2 ns after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_rtc_bus_ctrl;
   localparam int T_PH = 4;
`ifdef RTC_AUTO_CMD_EN
   localparam int WR_DONE = 15*T_PH + 1;
`else
   localparam int WR_DONE = 7*T_PH + 1;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       Acceso = 1'b0;
   logic       Mod = 1'b0;
   logic [7:0] Dir = 8'h00;
   logic [7:0] Dato_wr = 8'h00;
   logic [7:0] AD_in = 8'h00;
   logic       FRW, Busy, CS_n, AD_n, WR_n, RD_n, AD_oe;
   logic [7:0] Dato_rd, AD_out;

   always #5 CLK = ~CLK;

   rtc_bus_ctrl #(.T_PH(T_PH), .CMD_ADDR(8'hF1)) dut (
      .CLK(CLK), .RST(RST), .Acceso(Acceso), .Mod(Mod), .Dir(Dir),
      .Dato_wr(Dato_wr), .FRW(FRW), .Dato_rd(Dato_rd), .Busy(Busy),
      .CS_n(CS_n), .AD_n(AD_n), .WR_n(WR_n), .RD_n(RD_n),
      .AD_out(AD_out), .AD_oe(AD_oe), .AD_in(AD_in)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, req);
      end
   endtask

   // ---------------- timeline model ----------------
   typedef struct packed {
      logic       cs_n, ad_n, wr_n, rd_n, oe;
      logic [7:0] out;
      logic       frw, busy;
      logic [7:0] dato;
   } vec_t;

   vec_t       exp_q[$];
   logic [7:0] cur_dato = 8'h00;
   bit         init_pend = 1'b1;
   bit         acc_prev = 1'b1;

   function automatic vec_t quiet(input bit busy, input bit frw, input logic [7:0] d);
      vec_t v;
      v.cs_n = 1'b1; v.ad_n = 1'b1; v.wr_n = 1'b1; v.rd_n = 1'b1;
      v.oe = 1'b0; v.out = 8'h00; v.frw = frw; v.busy = busy; v.dato = d;
      return v;
   endfunction

   task automatic push_quiet(input int n, input bit frw, input logic [7:0] d);
      for (int i = 0; i < n; i++) exp_q.push_back(quiet(1'b1, frw, d));
   endtask

   // The seven phases of one transaction, T_PH cycles each.
   task automatic push_txn(input logic [7:0] a, input logic [7:0] d, input bit w,
                           input logic [7:0] d_before, input logic [7:0] d_after);
      vec_t v;
      for (int p = 0; p < 7; p++) begin
         for (int k = 0; k < T_PH; k++) begin
            v = quiet(1'b1, 1'b0, (p == 6) ? d_after : d_before);
            if (p != 3) v.cs_n = 1'b0;
            if (p < 3) begin v.ad_n = 1'b0; v.oe = 1'b1; v.out = a; end
            if (p == 1) v.wr_n = 1'b0;
            if (p >= 4 && w) begin v.oe = 1'b1; v.out = d; end
            if (p == 5) begin
               if (w) v.wr_n = 1'b0;
               else   v.rd_n = 1'b0;
            end
            exp_q.push_back(v);
         end
      end
   endtask

   always @(negedge CLK) begin
      vec_t e;
      if (RST) begin
         exp_q.delete();
         cur_dato  = 8'h00;
         init_pend = 1'b1;
         acc_prev  = 1'b1;
         e = quiet(1'b1, 1'b0, 8'h00);
      end else if (init_pend) begin
         init_pend = 1'b0;
         e = quiet(1'b1, 1'b0, cur_dato);
         push_txn(8'h02, 8'h10, 1'b1, cur_dato, cur_dato);
         push_quiet(T_PH, 1'b0, cur_dato);
         push_txn(8'h02, 8'h00, 1'b1, cur_dato, cur_dato);
         push_quiet(1, 1'b1, cur_dato);
         acc_prev = Acceso;
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cur_dato = e.dato;
         acc_prev = Acceso;
      end else begin
         e = quiet(1'b0, 1'b0, cur_dato);
         if (Acceso && !acc_prev) begin
            if (Mod) begin
               push_txn(Dir, Dato_wr, 1'b1, cur_dato, cur_dato);
`ifdef RTC_AUTO_CMD_EN
               if (Dir != 8'hF1) begin
                  push_quiet(T_PH, 1'b0, cur_dato);
                  push_txn(8'hF1, 8'h00, 1'b1, cur_dato, cur_dato);
               end
`endif
               push_quiet(1, 1'b1, cur_dato);
            end else begin
               push_txn(Dir, 8'h00, 1'b0, cur_dato, AD_in);
               push_quiet(1, 1'b1, AD_in);
            end
         end
         acc_prev = Acceso;
      end
      chk("CS_n", CS_n, e.cs_n);
      chk("AD_n", AD_n, e.ad_n);
      chk("WR_n", WR_n, e.wr_n);
      chk("RD_n", RD_n, e.rd_n);
      chk("AD_oe", AD_oe, e.oe);
      chk("AD_out", AD_out, e.out);
      chk("FRW", FRW, e.frw);
      chk("Busy", Busy, e.busy);
      chk("Dato_rd", Dato_rd, e.dato);
   end

   // ---------------- directed stimulus ----------------
   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge CLK);
         #2;
      end
   endtask

   task automatic at(input int c);
      goto(c);
      @(negedge CLK);
   endtask

   int r, e;

   initial begin
      // 1: init sequence after reset release
      repeat (3) @(posedge CLK);
      #2;
      RST = 1'b0;
      r = cyc;
      at(r);      chk("lit_rst_busy", Busy, 1'b1); chk("lit_rst_csn", CS_n, 1'b1);
      at(r + 1);  chk("lit_init1_addr", AD_out, 8'h02); chk("lit_init1_adn", AD_n, 1'b0);
      at(r + 17); chk("lit_init1_data", AD_out, 8'h10);
      at(r + 33); chk("lit_init2_addr", AD_out, 8'h02);
      at(r + 49); chk("lit_init2_data", AD_out, 8'h00); chk("lit_init2_oe", AD_oe, 1'b1);
      at(r + 60); chk("lit_init_frw_early", FRW, 1'b0);
      at(r + 61); chk("lit_init_frw", FRW, 1'b1);
      at(r + 62); chk("lit_init_busy_fall", Busy, 1'b0);

      // 2: read of 0x21 returning 0x45
      goto(r + 66);
      e = cyc;
      Mod = 1'b0; Dir = 8'h21; AD_in = 8'h45; Acceso = 1'b1;
      at(e);      chk("lit_rd_busy0", Busy, 1'b0);
      at(e + 1);  chk("lit_rd_addr", AD_out, 8'h21); chk("lit_rd_adn", AD_n, 1'b0);
      goto(e + 2); Acceso = 1'b0;
      at(e + 5);  chk("lit_rd_wrn_addr", WR_n, 1'b0);
      at(e + 21); chk("lit_rd_rdn", RD_n, 1'b0); chk("lit_rd_oe", AD_oe, 1'b0);
      at(e + 28); chk("lit_rd_frw_early", FRW, 1'b0);
      at(e + 29); chk("lit_rd_frw", FRW, 1'b1);
      at(e + 30); chk("lit_rd_dato", Dato_rd, 8'h45); chk("lit_rd_busy_fall", Busy, 1'b0);

      // 3: write 0x12 to 0x41
      goto(e + 34);
      e = cyc;
      Mod = 1'b1; Dir = 8'h41; Dato_wr = 8'h12; Acceso = 1'b1;
      at(e + 1);  chk("lit_wr_addr", AD_out, 8'h41); chk("lit_wr_oe_a", AD_oe, 1'b1);
      goto(e + 2); Acceso = 1'b0;
      at(e + 17); chk("lit_wr_data", AD_out, 8'h12); chk("lit_wr_oe_d", AD_oe, 1'b1);
      at(e + 21); chk("lit_wr_wrn", WR_n, 1'b0); chk("lit_wr_rdn", RD_n, 1'b1);
      at(e + WR_DONE); chk("lit_wr_frw", FRW, 1'b1); chk("lit_wr_dato_kept", Dato_rd, 8'h45);
      at(e + WR_DONE + 1); chk("lit_wr_busy_fall", Busy, 1'b0);

      // 4: long Acceso, dropped edge while busy, edge right after FRW
      goto(e + WR_DONE + 4);
      e = cyc;
      Mod = 1'b0; Dir = 8'h33; AD_in = 8'h5A; Acceso = 1'b1;
      goto(e + 8);  Acceso = 1'b0;
      goto(e + 10); Acceso = 1'b1;
      goto(e + 12); Acceso = 1'b0;
      at(e + 29); chk("lit_hold_frw", FRW, 1'b1); chk("lit_hold_dato", Dato_rd, 8'h5A);
      goto(e + 30);
      Mod = 1'b1; Dir = 8'h34; Dato_wr = 8'h77; Acceso = 1'b1;
      at(e + 30); chk("lit_hold_idle", Busy, 1'b0);
      at(e + 31); chk("lit_next_addr", AD_out, 8'h34); chk("lit_next_busy", Busy, 1'b1);
      goto(e + 32); Acceso = 1'b0;
      at(e + 30 + WR_DONE); chk("lit_next_frw", FRW, 1'b1);

      // 5: reset during the read strobe
      goto(e + 30 + WR_DONE + 4);
      e = cyc;
      Mod = 1'b0; Dir = 8'h55; AD_in = 8'h99; Acceso = 1'b1;
      goto(e + 2); Acceso = 1'b0;
      at(e + 21); chk("lit_pre_rst_rdn", RD_n, 1'b0);
      goto(e + 22);
      RST = 1'b1;
      #1;
      chk("lit_rst_rdn", RD_n, 1'b1); chk("lit_rst_wrn", WR_n, 1'b1);
      chk("lit_rst_csn2", CS_n, 1'b1); chk("lit_rst_oe", AD_oe, 1'b0);
      chk("lit_rst_dato", Dato_rd, 8'h00);
      goto(e + 25);
      RST = 1'b0;
      r = cyc;
      at(r + 1);  chk("lit_reinit_addr", AD_out, 8'h02); chk("lit_reinit_csn", CS_n, 1'b0);
      at(r + 61); chk("lit_reinit_frw", FRW, 1'b1);
      at(r + 62); chk("lit_reinit_busy", Busy, 1'b0);

      // 6: write to 0x22, with or without the automatic command write
      goto(r + 66);
      e = cyc;
      Mod = 1'b1; Dir = 8'h22; Dato_wr = 8'hAB; Acceso = 1'b1;
      goto(e + 2); Acceso = 1'b0;
`ifdef RTC_AUTO_CMD_EN
      at(e + 29); chk("lit_cmd_nofrw", FRW, 1'b0);
      at(e + 33); chk("lit_cmd_addr", AD_out, 8'hF1); chk("lit_cmd_adn", AD_n, 1'b0);
      at(e + 49); chk("lit_cmd_data", AD_out, 8'h00); chk("lit_cmd_oe", AD_oe, 1'b1);
      at(e + 61); chk("lit_cmd_frw", FRW, 1'b1);
`else
      at(e + 29); chk("lit_plain_frw", FRW, 1'b1);
      at(e + 33); chk("lit_plain_csn", CS_n, 1'b1); chk("lit_plain_out", AD_out, 8'h00);
      chk("lit_plain_busy", Busy, 1'b0);
`endif
      at(e + 70);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
